prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The module SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: begins program execution from IDLE.
REQ-004 The module SHALL have port instr, input, 9 bits: instruction word from instruction ROM at address prog_ctr.
REQ-005 The module SHALL have port zero_flag, input, 1 bit: ALU result-is-zero flag.
REQ-006 The module SHALL have port parity_flag, input, 1 bit: ALU XOR-reduction of result.
REQ-007 The module SHALL have port not_equal, input, 1 bit: ALU input_0 != input_1.
REQ-008 The module SHALL have port prog_ctr, output, 8 bits: instruction ROM address.
REQ-009 The module SHALL have port op_code, output, 3 bits: ALU operation select (AND, OR, ADD, SUB, XOR, LSL, LSR, MOV = 0..7).
REQ-010 The module SHALL have port reg_sel, output, 3 bits: register file read address for ALU input_1; input_0 is always R0.
REQ-011 The module SHALL have port reg_wr_en, output, 1 bit: write ALU result into R0 this cycle.
REQ-012 The module SHALL have port done, output, 1 bit: high while in HALT.

Function
REQ-013 Instruction decode SHALL be as follows. instr[8]=0 is ALU-type: op_code=instr[7:5], reg_sel=instr[4:2], instr[1:0] ignored. instr[8]=1 is control-type: sub=instr[7:6], off=instr[5:0] (signed, two's complement).
REQ-014 Control sub-codes SHALL be: 00 BZ (branch if latched Z), 01 BNE (branch if latched NE), 10 BPAR (see Configuration), 11 HALT.
REQ-015 The FSM SHALL have exactly four states: IDLE, FETCH, EXEC, HALT.
REQ-016 IDLE SHALL go to FETCH when start=1; otherwise it holds.
REQ-017 FETCH SHALL always go to EXEC.
REQ-018 EXEC SHALL go to HALT on a HALT instruction, else to FETCH.
REQ-019 HALT SHALL go to FETCH with prog_ctr=0 when start=1; otherwise it holds.
REQ-020 FETCH SHALL capture instr into an internal 9-bit instruction register (IR); all decode SHALL use IR, never the live instr.
REQ-021 Latency SHALL be 2 cycles per instruction: 1 fetch plus 1 execute.
REQ-022 During EXEC of an ALU-type instruction, reg_wr_en SHALL be 1 for exactly that cycle; reg_wr_en SHALL be 0 in all other states and for all control-type instructions.
REQ-023 op_code and reg_sel SHALL be driven from IR in EXEC and SHALL be 0 otherwise.
REQ-024 During EXEC of an ALU-type instruction, latched flags {Z,P,NE} SHALL be loaded from zero_flag, parity_flag and not_equal; control-type instructions SHALL leave the latched flags unchanged.
REQ-025 At the end of EXEC, prog_ctr SHALL update: taken branch gives prog_ctr+sext(off); otherwise prog_ctr+1; HALT leaves prog_ctr unchanged.
REQ-026 prog_ctr arithmetic SHALL be modulo 256: 255+1 gives 0; 2+(-4) gives 254.
REQ-027 A taken branch with off=0 SHALL re-execute the same instruction; this SHALL be legal.
REQ-028 start SHALL be ignored in FETCH and EXEC.
REQ-029 done SHALL be 1 in HALT only.

Reset
REQ-030 On Reset=1, regardless of Clk or current state, the module SHALL set: state=IDLE, prog_ctr=0, IR=0, latched flags Z=P=NE=0, op_code=0, reg_sel=0, reg_wr_en=0, done=0.
REQ-031 Reset asserted mid-instruction SHALL abort that instruction with no write pulse; execution restarts only on a subsequent start.

Configuration
REQ-032 With PARITY_BRANCH_EN defined, sub 10 (BPAR) SHALL branch when latched P=1.
REQ-033 Without PARITY_BRANCH_EN, sub 10 SHALL act as NOP: prog_ctr+1, flags unchanged, no write.

Verification
REQ-034 Reset release, start pulse, ROM[0]=ALU ADD reg_sel=1 (0_010_001_00), then ROM[1]=HALT: the bench SHALL check reg_wr_en high for 1 cycle with op_code=2 and reg_sel=1, then done=1 with prog_ctr=1.
REQ-035 ROM[0]=SUB with zero_flag=1, then ROM[1]=BZ off=+3: the bench SHALL check prog_ctr sequence 0,1,4; repeated with zero_flag=0, the sequence SHALL be 0,1,2.
REQ-036 Branch wrap: prog_ctr=2 executing BNE off=-4 (1_01_111100) with latched NE=1: the bench SHALL check next prog_ctr=254; sequential wrap from 255 SHALL give 0.
REQ-037 BPAR at prog_ctr=5 with latched P=1: with PARITY_BRANCH_EN and off=+2, next prog_ctr SHALL be 7; without the macro, next prog_ctr SHALL be 6.
REQ-038 Reset asserted in the EXEC cycle of an ALU instruction: the bench SHALL check reg_wr_en drops immediately, state=IDLE and prog_ctr=0, and that a start pulse after reset release resumes fetch from address 0.
REQ-039 Flag hold: ALU instruction sets Z=1, then a taken BNE/not-taken branch, then BZ: the bench SHALL check BZ is taken because the latched Z is unchanged by the intervening control instruction.

Source files
------------

// File: rtl/prog_sequencer.sv
// Two-cycle fetch/execute sequencer for a 9-bit accumulator ISA (ALU ops into R0, flag branches, HALT).
// Optional feature macro: PARITY_BRANCH_EN enables BPAR (branch on latched parity); otherwise BPAR is a NOP.
module prog_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [8:0] instr,
  input  logic       zero_flag,
  input  logic       parity_flag,
  input  logic       not_equal,
  output logic [7:0] prog_ctr,
  output logic [2:0] op_code,
  output logic [2:0] reg_sel,
  output logic       reg_wr_en,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t     state;
  logic [8:0] ir;
  logic       flag_z;
  logic       flag_p;
  logic       flag_ne;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       unused_bits;

  // Offset is a 6-bit two's-complement value; 8-bit wraparound gives modulo-256 targets.
  assign branch_target = prog_ctr + {{2{ir[5]}}, ir[5:0]};

  always_comb begin
    branch_taken = 1'b0;
    case (ir[7:6])
      2'b00: branch_taken = flag_z;
      2'b01: branch_taken = flag_ne;
`ifdef PARITY_BRANCH_EN
      2'b10: branch_taken = flag_p;
`else
      2'b10: branch_taken = 1'b0;
`endif
      default: branch_taken = 1'b0;
    endcase
  end

`ifdef PARITY_BRANCH_EN
  assign unused_bits = ^ir[1:0];
`else
  assign unused_bits = ^{ir[1:0], flag_p};
`endif

  // The EXEC-cycle outputs are loaded on the same edge that loads IR, from the same word,
  // so they are registered copies of IR fields and clear again when EXEC ends.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      prog_ctr  <= 8'd0;
      ir        <= 9'd0;
      flag_z    <= 1'b0;
      flag_p    <= 1'b0;
      flag_ne   <= 1'b0;
      op_code   <= 3'd0;
      reg_sel   <= 3'd0;
      reg_wr_en <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          ir        <= instr;
          op_code   <= instr[7:5];
          reg_sel   <= instr[4:2];
          reg_wr_en <= ~instr[8];
          state     <= EXEC;
        end
        EXEC: begin
          op_code   <= 3'd0;
          reg_sel   <= 3'd0;
          reg_wr_en <= 1'b0;
          if (!ir[8]) begin
            flag_z   <= zero_flag;
            flag_p   <= parity_flag;
            flag_ne  <= not_equal;
            prog_ctr <= prog_ctr + 8'd1;
            state    <= FETCH;
          end else if (ir[7:6] == 2'b11) begin
            done  <= 1'b1;
            state <= HALT;
          end else begin
            prog_ctr <= branch_taken ? branch_target : prog_ctr + 8'd1;
            state    <= FETCH;
          end
        end
        HALT: begin
          if (start) begin
            prog_ctr <= 8'd0;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
